// File: rtl/fifo_arb_ctrl_if.sv
// Handshake and memory-port bundle for fifo_arb_ctrl.
// The slave side is the controller. The master side is the writers, the reader and the memory.
interface fifo_arb_ctrl_if #(
    parameter int Data_width = 8,
    parameter int Address    = 3
);
    logic                  Req0;
    logic                  Req1;
    logic [Data_width-1:0] Wdata0;
    logic [Data_width-1:0] Wdata1;
    logic                  Gnt0;
    logic                  Gnt1;
    logic                  Rreq;
    logic                  Rvalid;
    logic                  Full;
    logic                  Empty;
    logic [Address:0]      Count;
    logic [Data_width-1:0] Mem_wrdata;
    logic [Address-1:0]    Mem_wadder;
    logic                  Mem_wclken;
    logic [Address-1:0]    Mem_radder;
    logic                  Mem_rempty;

    modport slave (
        input  Req0, Req1, Wdata0, Wdata1, Rreq,
        output Gnt0, Gnt1, Rvalid, Full, Empty, Count,
               Mem_wrdata, Mem_wadder, Mem_wclken, Mem_radder, Mem_rempty
    );

    modport master (
        output Req0, Req1, Wdata0, Wdata1, Rreq,
        input  Gnt0, Gnt1, Rvalid, Full, Empty, Count,
               Mem_wrdata, Mem_wadder, Mem_wclken, Mem_radder, Mem_rempty
    );
endinterface

// File: rtl/fifo_arb_ctrl.sv
// Two-writer round-robin FIFO controller. It owns the pointers, the occupancy count and the flags.
// It drives one external dual-port memory.
module fifo_arb_ctrl #(
    parameter int Data_width = 8,
    parameter int Depth      = 8,
    parameter int Address    = 3
) (
    input  logic              Clk,
    input  logic              Rst,
    fifo_arb_ctrl_if.slave    bus
);
    localparam logic [Address:0] DEPTH_C = (Address+1)'(Depth);

    logic [Address-1:0] wptr, rptr;
    logic [Address:0]   cnt;
    logic               last;
    logic               rvalid_q;
    logic               full, empty;
    logic               gnt0, gnt1, wr_acc, rd_acc;

    assign full  = (cnt == DEPTH_C);
    assign empty = (cnt == '0);

    // last=1 means writer 1 won most recently, so writer 0 takes the next tie
    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        if (!Rst && !full) begin
            gnt0 = bus.Req0 && (!bus.Req1 || last);
            gnt1 = bus.Req1 && (!bus.Req0 || !last);
        end
        wr_acc = gnt0 | gnt1;
        rd_acc = bus.Rreq && !empty && !Rst;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            last     <= 1'b1;
            rvalid_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
                last <= gnt1;
            end
            if (rd_acc)
                rptr <= rptr + 1'b1;
            if (wr_acc && !rd_acc)
                cnt <= cnt + 1'b1;
            else if (rd_acc && !wr_acc)
                cnt <= cnt - 1'b1;
            rvalid_q <= rd_acc;
        end
    end

    assign bus.Gnt0       = gnt0;
    assign bus.Gnt1       = gnt1;
    assign bus.Rvalid     = rvalid_q;
    assign bus.Full       = full;
    assign bus.Empty      = empty;
    assign bus.Count      = cnt;
    assign bus.Mem_wrdata = gnt1 ? bus.Wdata1 : bus.Wdata0;
    assign bus.Mem_wadder = wptr;
    assign bus.Mem_wclken = wr_acc;
    assign bus.Mem_radder = rptr;
    assign bus.Mem_rempty = !rd_acc;
endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Directed bench for fifo_arb_ctrl. It pairs the controller with a behavioural memory.
// It checks the controller against hand-computed vectors and a small occupancy model.
module tb_fifo_arb_ctrl;
    logic Clk = 1'b0;
    logic Rst;
    int   total = 0;
    int   bad   = 0;

    fifo_arb_ctrl_if #(.Data_width(8), .Address(3)) bus ();
    fifo_arb_ctrl #(.Data_width(8), .Depth(8), .Address(3)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    always #5 Clk = ~Clk;

    // memory instance stand-in: registered write, registered gated read
    logic [7:0] mem [8];
    logic [7:0] Rdata;
    always @(posedge Clk) begin
        if (bus.Mem_wclken) mem[bus.Mem_wadder] <= bus.Mem_wrdata;
        if (!bus.Mem_rempty) Rdata <= mem[bus.Mem_radder];
    end

    typedef struct {
        logic       rst, r0, r1;
        logic [7:0] w0, w1;
        logic       rq;
        logic       g0, g1, we, re;
        logic [7:0] wd;
        logic [2:0] wa, ra;
        logic [3:0] cnt;
        logic       rv;
    } vec_t;

    function automatic vec_t mk(logic rst, logic r0, logic r1, logic [7:0] w0, logic [7:0] w1,
                                logic rq, logic g0, logic g1, logic we, logic re, logic [7:0] wd,
                                logic [2:0] wa, logic [2:0] ra, logic [3:0] cnt, logic rv);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.rq = rq;
        v.g0 = g0; v.g1 = g1; v.we = we; v.re = re; v.wd = wd;
        v.wa = wa; v.ra = ra; v.cnt = cnt; v.rv = rv;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic r0, input logic r1, input logic [7:0] w0,
                         input logic [7:0] w1, input logic rq);
        Rst = rst; bus.Req0 = r0; bus.Req1 = r1; bus.Wdata0 = w0; bus.Wdata1 = w1; bus.Rreq = rq;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        Rst = 1'b0;
    endtask

    vec_t tbl[13];

    initial begin
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();

        //             rst r0 r1 w0     w1     rq  g0 g1 we re wd     wa ra cnt rv
        tbl[0]  = mk(1, 1, 1, 8'hA1, 8'hB1, 1, 0, 0, 0, 1, 8'hA1, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 8'h5A, 8'h00, 0, 0, 0, 0, 1, 8'h5A, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 8'h5A, 8'h00, 1, 0, 0, 0, 1, 8'h5A, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 8'h11, 8'h00, 0, 1, 0, 1, 1, 8'h11, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 8'h22, 8'h00, 0, 1, 0, 1, 1, 8'h22, 1, 0, 1, 0);
        tbl[5]  = mk(0, 1, 0, 8'h33, 8'h00, 1, 1, 0, 1, 0, 8'h33, 2, 0, 2, 0);
        tbl[6]  = mk(0, 0, 1, 8'h33, 8'hB0, 1, 0, 1, 1, 0, 8'hB0, 3, 1, 2, 1);
        tbl[7]  = mk(0, 0, 0, 8'h33, 8'hB0, 1, 0, 0, 0, 0, 8'h33, 4, 2, 2, 1);
        tbl[8]  = mk(0, 0, 0, 8'h33, 8'hB0, 1, 0, 0, 0, 0, 8'h33, 4, 3, 1, 1);
        tbl[9]  = mk(0, 0, 0, 8'h33, 8'hB0, 1, 0, 0, 0, 1, 8'h33, 4, 4, 0, 1);
        tbl[10] = mk(0, 1, 0, 8'h44, 8'hB0, 1, 1, 0, 1, 1, 8'h44, 4, 4, 0, 0);
        tbl[11] = mk(1, 1, 0, 8'h44, 8'hB0, 1, 0, 0, 0, 1, 8'h44, 5, 4, 1, 0);
        tbl[12] = mk(0, 0, 0, 8'h44, 8'hB0, 0, 0, 0, 0, 1, 8'h44, 0, 0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1, tbl[i].rq);
            @(negedge Clk);
            chk($sformatf("v%0d gnt0", i),   bus.Gnt0,       tbl[i].g0);
            chk($sformatf("v%0d gnt1", i),   bus.Gnt1,       tbl[i].g1);
            chk($sformatf("v%0d wclken", i), bus.Mem_wclken, tbl[i].we);
            chk($sformatf("v%0d rempty", i), bus.Mem_rempty, tbl[i].re);
            chk($sformatf("v%0d wrdata", i), bus.Mem_wrdata, tbl[i].wd);
            chk($sformatf("v%0d wadder", i), bus.Mem_wadder, tbl[i].wa);
            chk($sformatf("v%0d radder", i), bus.Mem_radder, tbl[i].ra);
            chk($sformatf("v%0d count", i),  bus.Count,      tbl[i].cnt);
            chk($sformatf("v%0d full", i),   bus.Full,       tbl[i].cnt == 4'd8);
            chk($sformatf("v%0d empty", i),  bus.Empty,      tbl[i].cnt == 4'd0);
            chk($sformatf("v%0d rvalid", i), bus.Rvalid,     tbl[i].rv);
            tick();
        end

        // single writer 0x11/0x22/0x33, then held read with data check
        begin
            logic [7:0] d [3];
            d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
            do_reset();
            for (int k = 0; k < 3; k++) begin
                drive(1'b0, 1'b1, 1'b0, d[k], 8'h00, 1'b0);
                @(negedge Clk);
                chk("seqA gnt0", bus.Gnt0, 1);
                chk("seqA wadder", bus.Mem_wadder, k);
                tick();
            end
            for (int k = 0; k < 5; k++) begin
                drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
                @(negedge Clk);
                chk("seqA rempty", bus.Mem_rempty, (k < 3) ? 0 : 1);
                chk("seqA rvalid", bus.Rvalid, (k >= 1 && k <= 3) ? 1 : 0);
                if (k >= 1 && k <= 3) chk("seqA rdata", Rdata, d[k-1]);
                tick();
            end
        end

        // both writers held: alternating grants until full
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 8'hA0, 8'hB0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            chk("seqB gnt0", bus.Gnt0, (k % 2 == 0) ? 1 : 0);
            chk("seqB gnt1", bus.Gnt1, (k % 2 == 1) ? 1 : 0);
            chk("seqB wrdata", bus.Mem_wrdata, (k % 2 == 0) ? 8'hA0 : 8'hB0);
            chk("seqB wadder", bus.Mem_wadder, k);
            tick();
        end
        @(negedge Clk);
        chk("seqB full", bus.Full, 1);
        chk("seqB count", bus.Count, 8);
        chk("seqB stall gnt", {bus.Gnt0, bus.Gnt1}, 0);
        chk("seqB stall wclken", bus.Mem_wclken, 0);
        tick();

        // full with read and pending writer 1: read wins, write follows
        drive(1'b0, 1'b0, 1'b1, 8'hA0, 8'hC1, 1'b1);
        @(negedge Clk);
        chk("seqC rempty", bus.Mem_rempty, 0);
        chk("seqC no gnt1", bus.Gnt1, 0);
        tick();
        bus.Rreq = 1'b0;
        @(negedge Clk);
        chk("seqC count7", bus.Count, 7);
        chk("seqC gnt1", bus.Gnt1, 1);
        chk("seqC wrdata", bus.Mem_wrdata, 8'hC1);
        tick();
        bus.Req1 = 1'b0;
        @(negedge Clk);
        chk("seqC count8", bus.Count, 8);
        chk("seqC refull", bus.Full, 1);
        tick();

        // 20 words through writer 0 with random reads, against an occupancy model
        begin
            logic [7:0] q[$];
            int mcnt = 0, mwp = 0, mrp = 0, wr_n = 0, rd_n = 0, cyc = 0;
            logic rv_exp = 1'b0, rv_nxt;
            logic [7:0] rv_data = 8'h00;
            logic eg, er;
            do_reset();
            while (rd_n < 20 || rv_exp) begin
                if (cyc == 600) begin
                    chk("seqD timeout", rd_n, 20);
                    break;
                end
                drive(1'b0, wr_n < 20, 1'b0, 8'(8'h40 + wr_n), 8'h00, 1'($urandom_range(0, 1)));
                @(negedge Clk);
                eg = bus.Req0 && (mcnt < 8);
                er = bus.Rreq && (mcnt != 0);
                chk("seqD gnt0", bus.Gnt0, eg);
                chk("seqD rempty", bus.Mem_rempty, !er);
                chk("seqD wadder", bus.Mem_wadder, mwp);
                chk("seqD radder", bus.Mem_radder, mrp);
                chk("seqD count", bus.Count, mcnt);
                chk("seqD rvalid", bus.Rvalid, rv_exp);
                if (rv_exp) chk("seqD rdata", Rdata, rv_data);
                rv_nxt = 1'b0;
                if (er) begin
                    rv_data = q.pop_front();
                    rv_nxt  = 1'b1;
                    rd_n++;
                    mrp = (mrp + 1) % 8;
                end
                if (eg) begin
                    q.push_back(bus.Wdata0);
                    wr_n++;
                    mwp = (mwp + 1) % 8;
                end
                mcnt = mcnt + (eg ? 1 : 0) - (er ? 1 : 0);
                rv_exp = rv_nxt;
                cyc++;
                tick();
            end
            drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
            @(negedge Clk);
            chk("seqD end wadder", bus.Mem_wadder, 4);
            chk("seqD end radder", bus.Mem_radder, 4);
            chk("seqD end empty", bus.Empty, 1);
            tick();
        end

        // reset with count=5 and a read in flight
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b1, 1'b0, 8'(k), 8'h00, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1);
        @(negedge Clk);
        chk("seqE pre count", bus.Count, 5);
        chk("seqE pre rvalid", bus.Rvalid, 1);
        chk("seqE rst gnt", {bus.Gnt0, bus.Gnt1}, 0);
        chk("seqE rst wclken", bus.Mem_wclken, 0);
        chk("seqE rst rempty", bus.Mem_rempty, 1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge Clk);
        chk("seqE rvalid", bus.Rvalid, 0);
        chk("seqE count", bus.Count, 0);
        chk("seqE empty", bus.Empty, 1);
        chk("seqE wadder", bus.Mem_wadder, 0);
        chk("seqE radder", bus.Mem_radder, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_arb_ctrl.md
# fifo_arb_ctrl

Single-clock controller that shares one dual-port FIFO memory write port between two writers and sequences the read port for one reader. It arbitrates writers round-robin and owns the write/read pointers, occupancy count and Full/Empty flags. It drives the memory's write address, write enable and read gate. It sits between two producer blocks, one consumer and a FIFO memory instance clocked on `Clk` at both ports.

## Interface
- `Data_width`, 8, data word width
- `Depth`, 8, FIFO entries; must equal 2^`Address`
- `Address`, 3, pointer width
- `Clk`  in  1  single clock; all logic on rising edge
- `Rst`  in  1  synchronous, active-high reset
- `Req0` / `Req1`  in  1  write request from writer 0 / 1; held with data until granted
- `Wdata0` / `Wdata1`  in  `Data_width`  write data from writer 0 / 1
- `Gnt0` / `Gnt1`  out  1  combinational; high in the cycle that writer's word is written
- `Rreq`  in  1  read request from consumer
- `Rvalid`  out  1  registered; memory `Rdata` is valid this cycle
- `Full`  out  1  `Count` == `Depth`
- `Empty`  out  1  `Count` == 0
- `Count`  out  `Address`+1  current occupancy
- `Mem_wrdata`  out  `Data_width`  data to memory write port
- `Mem_wadder`  out  `Address`  memory write address (= write pointer)
- `Mem_wclken`  out  1  memory write enable
- `Mem_radder`  out  `Address`  memory read address (= read pointer)
- `Mem_rempty`  out  1  memory read gate; memory captures when low

## Operation
- Write arbitration happens only when `Full`=0 and `Rst`=0:
  - One requester active: it is granted.
  - Both active: grant the writer that is not `Last`.
  - Exactly one grant per cycle at most.
- `Last` register records the most recent granted writer. Its reset value is 1, so writer 0 wins the first contest.
- When `Full`=1, no grant is issued even if a read is accepted in the same cycle. No full-bypass.
- Write accepted (`WrAcc` = `Gnt0`|`Gnt1`) drives the memory port:
  - `Mem_wclken`=1.
  - `Mem_wrdata` = granted writer's data (mux on grant; `Wdata0` when idle).
  - Write pointer increments mod `Depth` at the edge.
- Read accepted (`RdAcc`) = `Rreq` & !`Empty` & !`Rst`:
  - `Mem_rempty` = !`RdAcc`.
  - Read pointer increments mod `Depth` at the edge.
- A read is never accepted while `Empty`=1, including when a write lands in the same cycle. No empty-bypass.
- `Count` update:
  - +1 on `WrAcc` only.
  - −1 on `RdAcc` only.
  - Unchanged when both or neither.
- `Full` and `Empty` are combinational decodes of `Count`. `Count` never exceeds `Depth` and never underflows.
- Pointer wrap: `Depth`−1 → 0. Natural `Address`-bit overflow satisfies this because `Depth` = 2^`Address`.

## Timing
- Reset values, taking effect at the first edge with `Rst`=1:
  - Pointers 0, `Count` 0, `Empty` 1, `Full` 0, `Rvalid` 0, `Last` 1.
- While `Rst`=1, forced combinationally: `Gnt0`/`Gnt1`=0, `Mem_wclken`=0, `Mem_rempty`=1.
- Reset mid-operation: any in-flight `Rvalid` is dropped. Memory contents are left stale and unreachable.
- Write latency: a word granted in cycle N is in memory after edge N. It is readable (`Empty`=0) from cycle N+1.
- Read latency: `RdAcc` in cycle N; memory registers `Rdata` at edge N. `Rvalid`=1 in cycle N+1 only.
- Back-to-back `RdAcc` gives continuous `Rvalid`.
- Full FIFO with simultaneous `RdAcc` and pending write: the read completes. The write is granted in the next cycle.
- Writer handshake: a requester must hold `Req`/`Wdata` stable until it sees `Gnt`. Dropping `Req` early is allowed; nothing is written for it.

## Test plan
- Reset then idle: `Empty`=1, `Full`=0, `Count`=0, no grants, `Mem_rempty`=1, `Rvalid`=0.
- `Req0` alone writes 0x11, 0x22, 0x33 in three cycles, then `Rreq` held:
  - `Gnt0` high for 3 cycles; `Mem_wadder` = 0, 1, 2.
  - `Rvalid` on 3 consecutive cycles starting one cycle after the first read, data 0x11, 0x22, 0x33.
- `Req0` and `Req1` held continuously with 0xA0 and 0xB0:
  - Grants alternate 0, 1, 0, 1, … starting with writer 0.
  - After 8 grants, `Full`=1, `Count`=8 and grants stop.
- Full FIFO with `Rreq`=1 and `Req1`=1 in the same cycle:
  - Read accepted, no grant, `Count` 8→7.
  - Next cycle `Gnt1`=1 and `Count` returns to 8.
- Fill and drain 20 words through a single writer with `Rreq` random: `Mem_wadder` and `Mem_radder` wrap 7→0, and read data order matches write order.
- Assert `Rst` for one cycle with `Count`=5 and a read in flight: the next cycle shows `Rvalid`=0, `Count`=0, `Empty`=1 and pointers 0.
